// File: rtl/pq_pkg.sv
// Shared types and default widths for the priority-queue datapath.
package pq_pkg;

  localparam int unsigned KEY_WIDTH = 8;
  localparam int unsigned VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } pq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/pq_skid_fifo2.sv
// Two-entry FIFO; slot0 is always the head so the read data comes straight from a register.
module pq_skid_fifo2 #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_data_i,
  input  logic         wr_valid_i,
  output logic [W-1:0] rd_data_o,
  output logic         rd_valid_o,
  input  logic         rd_rdy_i,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         wr, rd;

  assign rd_valid_o = (cnt_q != 2'd0);
  assign rd_data_o  = slot0_q;
  assign count_o    = cnt_q;

  assign wr = wr_valid_i && (cnt_q != 2'd2);
  assign rd = rd_valid_o && rd_rdy_i;

  // Next-state: shift on read, fill lowest free slot on write.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    case ({wr, rd})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = wr_data_i;
        else               slot1_d = wr_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = wr_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = wr_data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pq_deadline_dispatch.sv
// Pops the priority-queue head once its key (a due time) is reached and buffers it for a sink.
module pq_deadline_dispatch
  import pq_pkg::*;
#(
  parameter int unsigned KEY_WIDTH   = pq_pkg::KEY_WIDTH,
  parameter int unsigned VAL_WIDTH   = pq_pkg::VAL_WIDTH,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned LATE_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_data,
  input  logic                           pq_valid,
  output logic                           pq_rdy,
  input  logic                           time_en,
  input  logic                           flush,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] out_data,
  output logic                           out_late,
  output logic                           out_valid,
  input  logic                           out_rdy,
  output logic [KEY_WIDTH-1:0]           now,
  output logic                           flush_done,
  output logic [CNT_W-1:0]               late_count,
  output logic [CNT_W-1:0]               disp_count
);

  localparam int unsigned ENT_W = KEY_WIDTH + VAL_WIDTH;
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [KEY_WIDTH-1:0] now_q, now_d;
  logic [DIV_W-1:0]     div_q, div_d;
  dispatch_state_t      state_q, state_d;
  logic [CNT_W-1:0]     late_cnt_q, late_cnt_d;
  logic [CNT_W-1:0]     disp_cnt_q, disp_cnt_d;

  logic [KEY_WIDTH-1:0] head_key;
  logic [KEY_WIDTH-1:0] diff;
  logic                 due;
  logic                 late;
  logic                 push;
  logic [1:0]           fifo_cnt;

  // Due/late compare; the MSB of (now - key) tells past from future across wrap.
  assign head_key = pq_data[ENT_W-1 -: KEY_WIDTH];
  assign diff     = now_q - head_key;
  assign due      = ~diff[KEY_WIDTH-1];
  assign late     = (state_q == RUN) && due && (diff > KEY_WIDTH'(LATE_THRESH));

  // Pop request is held low in reset so the queue never sees a pop while we are cleared.
  assign pq_rdy = rst_n && (due || (state_q == FLUSH)) && (fifo_cnt < 2'd2);
  assign push   = pq_valid && pq_rdy;

  assign now        = now_q;
  assign late_count = late_cnt_q;
  assign disp_count = disp_cnt_q;

  // Tick divider and time counter.
  always_comb begin
    now_d = now_q;
    div_d = div_q;
    if (time_en) begin
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
        div_d = '0;
        now_d = now_q + KEY_WIDTH'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // RUN/FLUSH next state; flush_done fires on the cycle FLUSH sees an empty queue.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (!pq_valid) begin
          state_d    = RUN;
          flush_done = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pop statistics: late count saturates, dispatch count wraps.
  always_comb begin
    late_cnt_d = late_cnt_q;
    disp_cnt_d = disp_cnt_q;
    if (push) begin
      disp_cnt_d = disp_cnt_q + CNT_W'(1);
      if (late && (late_cnt_q != '1)) late_cnt_d = late_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q      <= '0;
      div_q      <= '0;
      state_q    <= RUN;
      late_cnt_q <= '0;
      disp_cnt_q <= '0;
    end else begin
      now_q      <= now_d;
      div_q      <= div_d;
      state_q    <= state_d;
      late_cnt_q <= late_cnt_d;
      disp_cnt_q <= disp_cnt_d;
    end
  end

  pq_skid_fifo2 #(
    .W(ENT_W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  ({pq_data, late}),
    .wr_valid_i (push),
    .rd_data_o  ({out_data, out_late}),
    .rd_valid_o (out_valid),
    .rd_rdy_i   (out_rdy),
    .count_o    (fifo_cnt)
  );

endmodule

// File: tb/tb_pq_deadline_dispatch.sv
// Bench for pq_deadline_dispatch: queue model on the input, scoreboard on the output.
module tb_pq_deadline_dispatch;
  import pq_pkg::*;

  typedef struct packed {
    logic [7:0] key;
    logic [7:0] val;
    logic       late;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] pq_data;
  logic        pq_valid;
  logic        pq_rdy;
  logic        time_en;
  logic        flush;
  logic [15:0] out_data;
  logic        out_late;
  logic        out_valid;
  logic        out_rdy;
  logic [7:0]  now;
  logic        flush_done;
  logic [15:0] late_count;
  logic [15:0] disp_count;

  pq_entry_t src_q[$];
  exp_t      exp_q[$];
  int        checks;
  int        errors;
  logic      fire;

  pq_deadline_dispatch #(
    .KEY_WIDTH(8), .VAL_WIDTH(8), .TICK_DIV(1), .LATE_THRESH(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pq_data(pq_data), .pq_valid(pq_valid), .pq_rdy(pq_rdy),
    .time_en(time_en), .flush(flush), .out_data(out_data), .out_late(out_late),
    .out_valid(out_valid), .out_rdy(out_rdy), .now(now), .flush_done(flush_done),
    .late_count(late_count), .disp_count(disp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic refresh_pq();
    pq_valid = (src_q.size() != 0);
    pq_data  = pq_valid ? src_q[0] : 16'h0;
  endtask

  task automatic check_out();
    exp_t e;
    if (rst_n && out_valid && out_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got %h late %b, nothing expected", out_data, out_late);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== {e.key, e.val} || out_late !== e.late) begin
          errors++;
          $display("FAIL out_entry got %h late %b exp %h late %b", out_data, out_late,
                   {e.key, e.val}, e.late);
        end
      end
    end
  endtask

  // One clock: queue pops on the edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    fire = pq_valid && pq_rdy;
    #1;
    if (fire && src_q.size() != 0) void'(src_q.pop_front());
    refresh_pq();
    @(negedge clk);
    check_out();
  endtask

  task automatic push(input logic [7:0] key, input logic [7:0] val, input logic late);
    pq_entry_t s;
    exp_t      e;
    s.key = key; s.val = val;
    e.key = key; e.val = val; e.late = late;
    src_q.push_back(s);
    exp_q.push_back(e);
    refresh_pq();
  endtask

  task automatic set_out_rdy(input logic v);
    out_rdy = v;
    check_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || src_q.size() != 0); i++) tick();
    checks++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout got src %0d exp %0d left, need 0", name,
               src_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 6;
    if (now !== 8'd0)        begin errors++; $display("FAIL rst_now got %0d exp 0", now); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    if (pq_rdy !== 1'b0)     begin errors++; $display("FAIL rst_pq_rdy got %b exp 0", pq_rdy); end
    if (late_count !== 16'd0) begin errors++; $display("FAIL rst_late got %0d exp 0", late_count); end
    if (disp_count !== 16'd0) begin errors++; $display("FAIL rst_disp got %0d exp 0", disp_count); end
    if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_flush_done got %b exp 0", flush_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_due();
    do_reset();
    push(8'd5, 8'd14, 1'b0);
    time_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (now >= 8'd5) break;
      checks++;
      if (pq_rdy !== 1'b0) begin errors++; $display("FAIL due_early now %0d pq_rdy %b exp 0", now, pq_rdy); end
    end
    time_en = 1'b0;
    checks++;
    if (now !== 8'd5 || pq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL due_pop got now %0d pq_rdy %b exp now 5 pq_rdy 1", now, pq_rdy);
    end
    wait_drain("due");
    checks++;
    if (disp_count !== 16'd1) begin errors++; $display("FAIL due_disp got %0d exp 1", disp_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    time_en = 1'b1;
    tick();
    time_en = 1'b0;
    checks++;
    if (now !== 8'd1) begin errors++; $display("FAIL b2b_now got %0d exp 1", now); end
    set_out_rdy(1'b0);
    push(8'd0, 8'd1, 1'b0);
    push(8'd0, 8'd2, 1'b0);
    push(8'd1, 8'd3, 1'b0);
    repeat (4) tick();
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    if (pq_rdy !== 1'b0)    begin errors++; $display("FAIL b2b_full_rdy got %b exp 0", pq_rdy); end
    if (src_q.size() != 1)  begin errors++; $display("FAIL b2b_src got %0d exp 1", src_q.size()); end
    if (disp_count !== 16'd2) begin errors++; $display("FAIL b2b_disp got %0d exp 2", disp_count); end
    repeat (2) tick();
    checks++;
    if (out_data !== 16'h0001) begin errors++; $display("FAIL b2b_hold got %h exp 0001", out_data); end
    set_out_rdy(1'b1);
    wait_drain("b2b");
    checks++;
    if (disp_count !== 16'd3) begin errors++; $display("FAIL b2b_disp_end got %0d exp 3", disp_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    time_en = 1'b1;
    repeat (250) tick();
    checks++;
    if (now !== 8'd250) begin errors++; $display("FAIL wrap_now got %0d exp 250", now); end
    push(8'd3, 8'h33, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (now == 8'd3) break;
      checks++;
      if (pq_rdy !== 1'b0) begin errors++; $display("FAIL wrap_early now %0d pq_rdy %b exp 0", now, pq_rdy); end
    end
    time_en = 1'b0;
    checks++;
    if (now !== 8'd3 || pq_rdy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pop got now %0d pq_rdy %b exp now 3 pq_rdy 1", now, pq_rdy);
    end
    wait_drain("wrap");
  endtask

  task automatic test_flush();
    do_reset();
    push(8'd40, 8'd1, 1'b0);
    push(8'd80, 8'd2, 1'b0);
    tick();
    checks++;
    if (pq_rdy !== 1'b0) begin errors++; $display("FAIL flush_pre_rdy got %b exp 0", pq_rdy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (pq_rdy !== 1'b1 || src_q.size() != 2) begin
      errors++;
      $display("FAIL flush_first got rdy %b src %0d exp rdy 1 src 2", pq_rdy, src_q.size());
    end
    tick();
    checks++;
    if (pq_rdy !== 1'b1 || src_q.size() != 1) begin
      errors++;
      $display("FAIL flush_second got rdy %b src %0d exp rdy 1 src 1", pq_rdy, src_q.size());
    end
    tick();
    checks++;
    if (src_q.size() != 0 || flush_done !== 1'b1) begin
      errors++;
      $display("FAIL flush_done got src %0d done %b exp src 0 done 1", src_q.size(), flush_done);
    end
    tick();
    checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_pulse got %b exp 0", flush_done); end
    wait_drain("flush");
    checks += 2;
    if (late_count !== 16'd0) begin errors++; $display("FAIL flush_late got %0d exp 0", late_count); end
    if (disp_count !== 16'd2) begin errors++; $display("FAIL flush_disp got %0d exp 2", disp_count); end
  endtask

  task automatic test_late();
    do_reset();
    time_en = 1'b1;
    repeat (10) tick();
    time_en = 1'b0;
    checks++;
    if (now !== 8'd10) begin errors++; $display("FAIL late_now got %0d exp 10", now); end
    push(8'd2, 8'hA2, 1'b1);
    wait_drain("late1");
    checks++;
    if (late_count !== 16'd1) begin errors++; $display("FAIL late_cnt1 got %0d exp 1", late_count); end
    push(8'd8, 8'hA8, 1'b0);
    push(8'd6, 8'hA6, 1'b0);
    push(8'd5, 8'hA5, 1'b1);
    wait_drain("late2");
    checks += 2;
    if (late_count !== 16'd2) begin errors++; $display("FAIL late_cnt2 got %0d exp 2", late_count); end
    if (disp_count !== 16'd4) begin errors++; $display("FAIL late_disp got %0d exp 4", disp_count); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    set_out_rdy(1'b0);
    push(8'd0, 8'd1, 1'b0);
    push(8'd0, 8'd2, 1'b0);
    push(8'd0, 8'd3, 1'b0);
    time_en = 1'b1;
    repeat (3) tick();
    time_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (now !== 8'd0)        begin errors++; $display("FAIL mid_now got %0d exp 0", now); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    if (pq_rdy !== 1'b0)     begin errors++; $display("FAIL mid_rdy got %b exp 0", pq_rdy); end
    if (disp_count !== 16'd0 || late_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_counts got disp %0d late %0d exp 0 0", disp_count, late_count);
    end
    if (src_q.size() != 1)   begin errors++; $display("FAIL mid_src got %0d exp 1", src_q.size()); end
    exp_q.delete();
    e.key = 8'd0; e.val = 8'd3; e.late = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
    set_out_rdy(1'b1);
    wait_drain("mid");
    checks++;
    if (disp_count !== 16'd1) begin errors++; $display("FAIL mid_disp got %0d exp 1", disp_count); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fire     = 1'b0;
    rst_n    = 1'b0;
    time_en  = 1'b0;
    flush    = 1'b0;
    out_rdy  = 1'b1;
    pq_valid = 1'b0;
    pq_data  = 16'h0;
    test_reset();
    test_due();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_late();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
